// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared state encoding, RAM opcodes and default sizes for the SPI RAM slice.
package spi_ram_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;
endpackage

// File: rtl/spi_ram.sv
// spi_ram: single-port byte RAM driven by decoded 10-bit SPI commands.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);
  logic [7:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic [1:0] opcode;
  assign opcode = rx_data[9:8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      dout <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rx_valid && opcode == RD_DATA;
      if (rx_valid && opcode == WR_ADDR) wr_addr <= rx_data[ADDR_SIZE-1:0];
      if (rx_valid && opcode == RD_ADDR) rd_addr <= rx_data[ADDR_SIZE-1:0];
      if (rx_valid && opcode == RD_DATA) dout <= mem[rd_addr];
    end
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (rx_valid && opcode == WR_DATA) mem[wr_addr] <= rx_data[7:0];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: frames MOSI into 10-bit commands and shifts RAM read data out on MISO.
module spi_slave
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MOSI,
  input  logic       ss_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       MISO,
  output logic       rx_valid,
  output logic [9:0] rx_data
);
  state_t state, next_state;
  logic [3:0] cnt;
  logic [8:0] shift;
  logic [6:0] tx_shift;
  logic [2:0] tx_cnt;
  logic rd_addr_received;
  logic rx_active;
  assign rx_active = (state == WRITE || state == READ_ADD || state == READ_DATA) && cnt != 4'd10;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (ss_n) next_state = IDLE;
    else if (state == IDLE) next_state = CHK_CMD;
    else if (state == CHK_CMD) next_state = !MOSI ? WRITE : rd_addr_received ? READ_DATA : READ_ADD;
  end
  // cnt saturates at 10 so a finished frame ignores MOSI until ss_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_shift <= '0;
      tx_cnt <= '0;
      MISO <= 1'b0;
      rd_addr_received <= 1'b0;
    end else if (ss_n) begin
      cnt <= '0;
      rx_valid <= 1'b0;
      tx_cnt <= '0;
      MISO <= 1'b0;
    end else begin
      rx_valid <= rx_active && cnt == 4'd9;
      if (rx_active) begin
        shift <= {shift[7:0], MOSI};
        cnt <= cnt + 4'd1;
      end
      if (rx_active && cnt == 4'd9) begin
        rx_data <= {shift, MOSI};
        if (state == READ_ADD) rd_addr_received <= 1'b1;
      end
      if (state == READ_DATA && tx_valid) begin
        MISO <= tx_data[7];
        tx_shift <= tx_data[6:0];
        tx_cnt <= 3'd7;
      end else if (tx_cnt != 3'd0) begin
        MISO <= tx_shift[6];
        tx_shift <= {tx_shift[5:0], 1'b0};
        tx_cnt <= tx_cnt - 3'd1;
        if (tx_cnt == 3'd1) rd_addr_received <= 1'b0;
      end else MISO <= 1'b0;
    end
endmodule

// File: rtl/spi_wrapper.sv
// spi_wrapper: SPI slave front-end joined to a byte RAM.
module spi_wrapper
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic ss_n,
  output logic MISO
);
  logic [9:0] rx_data;
  logic rx_valid, tx_valid;
  logic [7:0] dout;
  spi_slave u_slave (
    .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .ss_n(ss_n),
    .tx_valid(tx_valid), .tx_data(dout),
    .MISO(MISO), .rx_valid(rx_valid), .rx_data(rx_data)
  );
  spi_ram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_ram (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid)
  );
endmodule

// File: tb/tb_spi_wrapper.sv
// tb_spi_wrapper: directed SPI frames with queued expectations checked by a monitor.
module tb_spi_wrapper;
  import spi_ram_pkg::*;
  logic clk = 1'b0;
  logic rst_n, MOSI, ss_n, MISO;
  int tests = 0, fails = 0;
  logic [9:0] rx_q[$];
  logic [7:0] tx_q[$], miso_q[$];
  int miso_cnt = 0;
  logic [7:0] miso_exp, miso_got;
  logic [9:0] rx_exp;
  logic [7:0] tx_exp;

  spi_wrapper dut (.clk(clk), .rst_n(rst_n), .MOSI(MOSI), .ss_n(ss_n), .MISO(MISO));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // path bit, then nbits of din MSB first, ss_n held low for hold extra edges
  task automatic send(input logic path, input logic [9:0] din, input int nbits = 10, input int hold = 10);
    @(negedge clk); ss_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = path;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); MOSI = din[9-i];
    end
    repeat (hold) @(negedge clk);
    @(negedge clk); ss_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (dut.rx_valid) begin
      if (rx_q.size() == 0) check("rx_unexpected", {6'd0, dut.rx_data}, 16'hFFFF);
      else begin
        rx_exp = rx_q.pop_front();
        check("rx_data", {6'd0, dut.rx_data}, {6'd0, rx_exp});
      end
    end
    if (miso_cnt == 0) check("miso_idle", {15'd0, MISO}, 16'd0);
    else if (miso_cnt <= 8) begin
      miso_got = {miso_got[6:0], MISO};
      if (miso_cnt == 8) check("miso_byte", {8'd0, miso_got}, {8'd0, miso_exp});
    end else check("miso_after", {15'd0, MISO}, 16'd0);
    miso_cnt = (miso_cnt == 0 || miso_cnt == 9) ? 0 : miso_cnt + 1;
    if (dut.tx_valid) begin
      if (tx_q.size() == 0 || miso_q.size() == 0) check("tx_unexpected", {8'd0, dut.dout}, 16'hFFFF);
      else begin
        tx_exp = tx_q.pop_front();
        miso_exp = miso_q.pop_front();
        check("tx_dout", {8'd0, dut.dout}, {8'd0, tx_exp});
        miso_cnt = 1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; MOSI = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_miso", {15'd0, MISO}, 16'd0);
    check("rst_state", 16'(dut.u_slave.state), 16'(IDLE));
    check("rst_flag", {15'd0, dut.u_slave.rd_addr_received}, 16'd0);
    check("rst_wr_addr", {8'd0, dut.u_ram.wr_addr}, 16'd0);
    check("rst_rd_addr", {8'd0, dut.u_ram.rd_addr}, 16'd0);
    check("rst_dout", {8'd0, dut.dout}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    ss_n = 1'b0; MOSI = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_state", 16'(dut.u_slave.state), 16'(IDLE));
    check("midrst_cnt", {12'd0, dut.u_slave.cnt}, 16'd0);
    check("midrst_miso", {15'd0, MISO}, 16'd0);
    @(negedge clk); ss_n = 1'b1; rst_n = 1'b1;
    @(negedge clk);

    rx_q.push_back(10'h0F0); send(1'b0, 10'h0F0);
    check("wr_addr_F0", {8'd0, dut.u_ram.wr_addr}, 16'h00F0);
    rx_q.push_back(10'h1A5); send(1'b0, 10'h1A5);
    check("mem_F0", {8'd0, dut.u_ram.mem[8'hF0]}, 16'h00A5);
    rx_q.push_back(10'h03C); send(1'b0, 10'h03C);
    rx_q.push_back(10'h15A); send(1'b0, 10'h15A);
    check("mem_3C", {8'd0, dut.u_ram.mem[8'h3C]}, 16'h005A);

    rx_q.push_back(10'h2F0); send(1'b1, 10'h2F0);
    check("flag_set", {15'd0, dut.u_slave.rd_addr_received}, 16'd1);
    check("rd_addr_F0", {8'd0, dut.u_ram.rd_addr}, 16'h00F0);
    rx_q.push_back(10'h300); tx_q.push_back(8'hA5); miso_q.push_back(8'hA5);
    send(1'b1, 10'h300);
    check("flag_clr", {15'd0, dut.u_slave.rd_addr_received}, 16'd0);

    rx_q.push_back(10'h23C); send(1'b1, 10'h23C);
    check("flag_readdr", {15'd0, dut.u_slave.rd_addr_received}, 16'd1);
    check("rd_addr_3C", {8'd0, dut.u_ram.rd_addr}, 16'h003C);
    rx_q.push_back(10'h3FF); tx_q.push_back(8'h5A); miso_q.push_back(8'h5A);
    send(1'b1, 10'h3FF);
    check("flag_clr2", {15'd0, dut.u_slave.rd_addr_received}, 16'd0);

    rx_q.push_back(10'h2F0); send(1'b0, 10'h2F0);
    check("mismatch_rd_addr", {8'd0, dut.u_ram.rd_addr}, 16'h00F0);
    check("mismatch_flag", {15'd0, dut.u_slave.rd_addr_received}, 16'd0);

    send(1'b0, 10'h1FF, 5, 0);
    check("abort_state", 16'(dut.u_slave.state), 16'(IDLE));
    check("abort_wr_addr", {8'd0, dut.u_ram.wr_addr}, 16'h003C);
    check("abort_mem_3C", {8'd0, dut.u_ram.mem[8'h3C]}, 16'h005A);
    check("abort_mem_F0", {8'd0, dut.u_ram.mem[8'hF0]}, 16'h00A5);
    check("abort_rd_addr", {8'd0, dut.u_ram.rd_addr}, 16'h00F0);

    repeat (12) @(negedge clk);
    check("rx_q_drained", 16'(rx_q.size()), 16'd0);
    check("tx_q_drained", 16'(tx_q.size()), 16'd0);
    check("miso_done", 16'(miso_cnt), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
